// File: rtl/led_sequencer_if.sv
// LED sequencer bus: pattern-select/pause controls in, LED pattern and step strobe out.
interface led_sequencer_if #(
  parameter int unsigned N_LEDS = 4
);
  logic [1:0]        mode;
  logic              pause;
  logic [N_LEDS-1:0] led;
  logic              step_pulse;

  modport master (
    output mode,
    output pause,
    input  led,
    input  step_pulse
  );

  modport slave (
    input  mode,
    input  pause,
    output led,
    output step_pulse
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled tick steps a SHIFT / FILL / BOUNCE / BLINK pattern.
// Optional feature: define LED_SEQ_BOUNCE_EN to build BOUNCE mode (mode 10) with its
// direction register; otherwise mode 10 is treated as SHIFT.
module led_sequencer #(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic            clk,
  input  logic            reset,
  led_sequencer_if.slave  bus
);

  localparam int unsigned       CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]   CntOne = CntW'(1);
  localparam logic [N_LEDS-1:0] LedOne = N_LEDS'(1);

  typedef enum logic [1:0] {
    ModeShift  = 2'b00,
    ModeFill   = 2'b01,
    ModeBounce = 2'b10,
    ModeBlink  = 2'b11
  } mode_e;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_LEDS-1:0] led_q, led_d;
  mode_e             mode_q, mode_d;
  logic              step_q, step_d;
`ifdef LED_SEQ_BOUNCE_EN
  logic              dir_up_q, dir_up_d;
`endif

  logic              tick;
  mode_e             mode_req;
  logic              is_onehot;
  logic              is_therm;
  logic              is_flat;
  logic [N_LEDS-1:0] led_dec;
  logic [N_LEDS-1:0] led_inc;

  assign tick = (cnt_q == CntMax) && !bus.pause;

  // Requested mode as the datapath sees it; without BOUNCE, 10 aliases to SHIFT.
  always_comb begin
    mode_req = mode_e'(bus.mode);
`ifndef LED_SEQ_BOUNCE_EN
    if (mode_req == ModeBounce) mode_req = ModeShift;
`endif
  end

  // Legality of the current pattern for each family of modes.
  always_comb begin
    led_dec   = led_q - LedOne;
    led_inc   = led_q + LedOne;
    is_onehot = (led_q != '0) && ((led_q & led_dec) == '0);
    is_therm  = ((led_q & led_inc) == '0);
    is_flat   = (led_q == '0) || (&led_q);
  end

  // Next-state: prescaler, mode switch on tick, and per-mode pattern advance.
  always_comb begin
    cnt_d    = cnt_q;
    led_d    = led_q;
    mode_d   = mode_q;
    step_d   = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    dir_up_d = dir_up_q;
`endif
    if (!bus.pause) cnt_d = tick ? '0 : cnt_q + CntOne;
    if (tick) begin
      step_d = 1'b1;
      if (mode_req != mode_q) begin
        mode_d = mode_req;
        led_d  = (mode_req == ModeBlink) ? '1 : LedOne;
`ifdef LED_SEQ_BOUNCE_EN
        dir_up_d = 1'b1;
`endif
      end else begin
        unique case (mode_q)
          ModeShift: led_d = is_onehot ? {led_q[N_LEDS-2:0], led_q[N_LEDS-1]} : LedOne;
          ModeFill: begin
            if (!is_therm)   led_d = LedOne;
            else if (&led_q) led_d = '0;
            else             led_d = {led_q[N_LEDS-2:0], 1'b1};
          end
`ifdef LED_SEQ_BOUNCE_EN
          ModeBounce: begin
            if (!is_onehot) begin
              led_d    = LedOne;
              dir_up_d = 1'b1;
            end else if (dir_up_q) begin
              // Top endpoint is shown once, then the walk turns around.
              if (led_q[N_LEDS-1]) begin
                led_d    = led_q >> 1;
                dir_up_d = 1'b0;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d    = led_q << 1;
                dir_up_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
`endif
          ModeBlink: led_d = is_flat ? ~led_q : '1;
          default:   led_d = LedOne;
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      led_q    <= LedOne;
      mode_q   <= ModeShift;
      step_q   <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign bus.led        = led_q;
  assign bus.step_pulse = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: two instances (TICK_DIV 1 and 3) against a step-index model.
module tb_led_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       pause;

  always #5 clk = ~clk;

  led_sequencer_if #(.N_LEDS(N)) if_a ();
  led_sequencer_if #(.N_LEDS(N)) if_b ();

  assign if_a.mode  = mode;
  assign if_a.pause = pause;
  assign if_b.mode  = mode;
  assign if_b.pause = pause;

  led_sequencer #(.N_LEDS(N), .TICK_DIV(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  led_sequencer #(.N_LEDS(N), .TICK_DIV(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: prescaler count, step index within the active pattern, active mode.
  int         m_cnt  [2];
  int         m_k    [2];
  logic [1:0] m_am   [2];
  logic       m_step [2];

  function automatic int tick_div(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef LED_SEQ_BOUNCE_EN
    return m;
`else
    return (m == 2'b10) ? 2'b00 : m;
`endif
  endfunction

  // Pattern shown k steps after a mode's start pattern.
  function automatic logic [N-1:0] pattern(input logic [1:0] m, input int k);
    logic [N-1:0] v;
    int p;
    v = '0;
    case (m)
      2'b00: begin
        p = k % N;
        v[p] = 1'b1;
      end
      2'b01: begin
        p = (k % (N + 1)) + 1;
        for (int j = 0; j < N; j++) if (j < p && p <= N) v[j] = 1'b1;
      end
      2'b10: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        v[p] = 1'b1;
      end
      default: v = (k % 2 == 0) ? '1 : '0;
    endcase
    return v;
  endfunction

  task automatic model_edge(input int i);
    logic t;
    if (!reset) begin
      m_cnt[i]  = 0;
      m_k[i]    = 0;
      m_am[i]   = 2'b00;
      m_step[i] = 1'b0;
    end else if (pause) begin
      m_step[i] = 1'b0;
    end else begin
      t = (m_cnt[i] == tick_div(i) - 1);
      m_cnt[i]  = t ? 0 : m_cnt[i] + 1;
      m_step[i] = t;
      if (t) begin
        if (eff_mode(mode) != m_am[i]) begin
          m_am[i] = eff_mode(mode);
          m_k[i]  = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("a.led",  if_a.led,                pattern(m_am[0], m_k[0]));
    check("a.step", {3'b000, if_a.step_pulse}, {3'b000, m_step[0]});
    check("b.led",  if_b.led,                pattern(m_am[1], m_k[1]));
    check("b.step", {3'b000, if_b.step_pulse}, {3'b000, m_step[1]});
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  logic [N-1:0] shift_seq [4];

  initial begin
    shift_seq[0] = 4'b0010;
    shift_seq[1] = 4'b0100;
    shift_seq[2] = 4'b1000;
    shift_seq[3] = 4'b0001;

    reset = 1'b0;
    mode  = 2'b11;
    pause = 1'b1;
    run(2);
    check("reset.led", if_a.led, 4'b0001);

    // Plain SHIFT from reset at one step per cycle, against a fixed table.
    mode  = 2'b00;
    pause = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check($sformatf("shift_tbl%0d", c), if_a.led, shift_seq[c]);
    end

    // FILL on both instances, several full periods.
    mode = 2'b01;
    run(20);

    // BOUNCE (or SHIFT alias when the feature is absent).
    mode = 2'b10;
    run(14);

    // Pause mid-pattern, then resume.
    mode = 2'b00;
    run(3);
    pause = 1'b1;
    run(5);
    pause = 1'b0;
    run(3);

    // Switch to BLINK between ticks.
    mode = 2'b11;
    run(9);

    // One-cycle reset mid-FILL, resuming with a non-SHIFT mode request.
    mode = 2'b01;
    run(8);
    reset = 1'b0;
    run(1);
    check("rst_mid.led", if_b.led, 4'b0001);
    reset = 1'b1;
    run(6);

    // Randomized mode/pause/reset activity.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
